// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// State encoding, default base address and bus widths.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = WORD_W / 8;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a CPU-side master and the
// memory responder; request signals are held until o_ready.
interface mem_responder_if;
    import mem_pkg::*;

    logic              i_memread;
    logic              i_memwrite;
    logic [31:0]       i_memaddr;
    logic [WORD_W-1:0] i_wdata;
    logic [STRB_W-1:0] i_wstrb;
    logic [WORD_W-1:0] o_rdata;
    logic              o_ready;
    logic              o_fault;

    modport master (
        output i_memread,
        output i_memwrite,
        output i_memaddr,
        output i_wdata,
        output i_wstrb,
        input  o_rdata,
        input  o_ready,
        input  o_fault
    );

    modport slave (
        input  i_memread,
        input  i_memwrite,
        input  i_memaddr,
        input  i_wdata,
        input  i_wstrb,
        output o_rdata,
        output o_ready,
        output o_fault
    );

endinterface

// File: rtl/mem_array.sv
// Single-port byte-enabled RAM with a registered read port.
// Contents are never cleared; reads return the pre-write word.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Byte-lane writes and synchronous read on the enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < int'(STRB_W); b++) begin
                    if (i_wstrb[b]) begin
                        mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
            rdata_q <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one request, checks it,
// then completes it with a one-cycle o_ready pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              is_write_q, is_write_d;
    logic              fault_q, fault_d;
    logic              ready_q, ready_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              rsp_rd_q, rsp_rd_d;

    logic [31:0]       offset;
    logic              in_range;
    logic              req;
    logic              bad;
    logic              ram_en;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;

    // Address decode and fault classification of the live request.
    always_comb begin
        offset   = bus.i_memaddr - BASE_ADDR;
        in_range = (offset >> 2) < 32'(DEPTH_WORDS);
        req      = bus.i_memread | bus.i_memwrite;
        bad      = !in_range
                 || (bus.i_memaddr[1:0] != 2'b00)
                 || (bus.i_memread && bus.i_memwrite);
    end

    // Next-state logic; ready_q blocks re-accepting a held request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        is_write_d  = is_write_q;
        fault_d     = fault_q;
        ready_d     = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rd_d    = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req && !ready_q) begin
                    idx_d      = offset[AW+1:2];
                    wdata_d    = bus.i_wdata;
                    wstrb_d    = bus.i_wstrb;
                    is_write_d = bus.i_memwrite;
                    fault_d    = bad;
                    cnt_d      = CNT_LOAD;
                    state_d    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                ready_d     = 1'b1;
                rsp_fault_d = fault_q;
                rsp_rd_d    = !fault_q && !is_write_q;
                ram_en      = !fault_q;
                ram_we      = !fault_q && is_write_q && !i_reset;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered response flags; reset aborts any request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            is_write_q  <= 1'b0;
            fault_q     <= 1'b0;
            ready_q     <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            is_write_q  <= is_write_d;
            fault_q     <= fault_d;
            ready_q     <= ready_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_en    (ram_en),
        .i_we    (ram_we),
        .i_addr  (idx_q),
        .i_wdata (wdata_q),
        .i_wstrb (wstrb_q),
        .o_rdata (ram_rdata)
    );

    assign bus.o_ready = ready_q;
    assign bus.o_fault = rsp_fault_q;
    assign bus.o_rdata = rsp_rd_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one 2-wait-state instance
// and one zero-wait-state instance sharing clock and reset.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_responder_if b0();
    mem_responder_if b1();

    mem_responder #(
        .BASE_ADDR   (32'h8000_0000),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2)
    ) dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (b0)
    );

    mem_responder #(
        .BASE_ADDR   (32'h8000_0000),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (0)
    ) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (b1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (sel) begin
            b1.i_memread  = rd;
            b1.i_memwrite = wr;
            b1.i_memaddr  = a;
            b1.i_wdata    = d;
            b1.i_wstrb    = s;
        end else begin
            b0.i_memread  = rd;
            b0.i_memwrite = wr;
            b0.i_memaddr  = a;
            b0.i_wdata    = d;
            b0.i_wstrb    = s;
        end
    endtask

    task automatic sample(input bit sel, output logic r, output logic f,
                          output logic [31:0] q);
        if (sel) begin
            r = b1.o_ready;
            f = b1.o_fault;
            q = b1.o_rdata;
        end else begin
            r = b0.o_ready;
            f = b0.o_fault;
            q = b0.o_rdata;
        end
    endtask

    // One request; latency counted in edges after the accept edge.
    task automatic xact(input string tag, input bit sel,
                        input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit mutate,
                        input int exp_lat, input logic exp_flt,
                        input logic [31:0] exp_rd);
        logic r, f;
        logic [31:0] q;
        int lat;
        bit quiet, single;
        logic flt;
        logic [31:0] rdata;
        lat = -1;
        quiet = 1'b1;
        single = 1'b1;
        flt = 1'b0;
        rdata = '0;
        @(posedge clk); #1;
        drive(sel, rd, wr, a, d, s);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (mutate && n == 1) begin
                drive(sel, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
            end
            sample(sel, r, f, q);
            if (r) begin
                lat = n - 1;
                flt = f;
                rdata = q;
                break;
            end
            if (f || q != 0) quiet = 1'b0;
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        sample(sel, r, f, q);
        if (r || f || q != 0) single = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_fault"}, 32'(flt), 32'(exp_flt));
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_quiet"}, 32'(quiet), 32'd1);
        chk({tag, "_pulse"}, 32'(single), 32'd1);
    endtask

    initial begin
        logic r, f;
        logic [31:0] q;
        bit seen;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        sample(1'b0, r, f, q);
        chk("rst_ready", 32'(r), 32'd0);
        chk("rst_fault", 32'(f), 32'd0);
        chk("rst_rdata", q, 32'h0);
        rst = 1'b0;

        xact("wr_beef", 0, 0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,
             0, 3, 0, 32'h0);
        xact("rd_beef", 0, 1, 0, 32'h8000_0010, 32'h0, 4'h0,
             0, 3, 0, 32'hDEAD_BEEF);
        xact("wr_byte0", 0, 0, 1, 32'h8000_0010, 32'h0000_00AA, 4'b0001,
             0, 3, 0, 32'h0);
        xact("rd_beaa", 0, 1, 0, 32'h8000_0010, 32'h0, 4'h0,
             0, 3, 0, 32'hDEAD_BEAA);
        xact("rd_misal", 0, 1, 0, 32'h8000_0012, 32'h0, 4'h0,
             0, 3, 1, 32'h0);
        xact("rd_below", 0, 1, 0, 32'h7FFF_FFFC, 32'h0, 4'h0,
             0, 3, 1, 32'h0);
        xact("rd_above", 0, 1, 0, 32'h8000_1000, 32'h0, 4'h0,
             0, 3, 1, 32'h0);
        xact("wr_misal", 0, 0, 1, 32'h8000_0011, 32'h0, 4'hF,
             0, 3, 1, 32'h0);
        xact("wr_nostrb", 0, 0, 1, 32'h8000_0010, 32'h0, 4'h0,
             0, 3, 0, 32'h0);
        xact("rd_kept", 0, 1, 0, 32'h8000_0010, 32'h0, 4'h0,
             0, 3, 0, 32'hDEAD_BEAA);
        xact("wr_last", 0, 0, 1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF,
             0, 3, 0, 32'h0);
        xact("rd_last", 0, 1, 0, 32'h8000_0FFC, 32'h0, 4'h0,
             0, 3, 0, 32'h0BAD_F00D);

        xact("wr_mut", 0, 0, 1, 32'h8000_0030, 32'h1234_5678, 4'hF,
             1, 3, 0, 32'h0);
        xact("rd_mut", 0, 1, 0, 32'h8000_0030, 32'h0, 4'h0,
             0, 3, 0, 32'h1234_5678);
        xact("rd_mut_kept", 0, 1, 0, 32'h8000_0010, 32'h0, 4'h0,
             0, 3, 0, 32'hDEAD_BEAA);

        xact("wr_pre", 0, 0, 1, 32'h8000_0020, 32'h1122_3344, 4'hF,
             0, 3, 0, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h8000_0020, 32'h5566_7788, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        sample(0, r, f, q);
        chk("midrst_ready", 32'(r), 32'd0);
        chk("midrst_fault", 32'(f), 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            sample(0, r, f, q);
            if (r || f) seen = 1'b1;
        end
        chk("midrst_noresp", 32'(seen), 32'd0);
        xact("rd_after_rst", 0, 1, 0, 32'h8000_0020, 32'h0, 4'h0,
             0, 3, 0, 32'h1122_3344);

        xact("w0_wr", 1, 0, 1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF,
             0, 1, 0, 32'h0);
        xact("w0_both", 1, 1, 1, 32'h8000_0040, 32'h0, 4'hF,
             0, 1, 1, 32'h0);
        xact("w0_rd", 1, 1, 0, 32'h8000_0040, 32'h0, 4'h0,
             0, 1, 0, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
